conv12_frame_loader: RTL



---
 rtl/conv12_pkg.sv | 15 +
 rtl/conv12_frame_loader_if.sv | 26 ++
 rtl/conv12_row_store.sv | 30 +++
 rtl/conv12_frame_loader.sv | 98 +++++++++
 4 files changed

// File: rtl/conv12_pkg.sv
// Shared sizes and fill-state encoding for the 12x12 convolution frame loader.
package conv12_pkg;
  localparam int PIX_W   = 2;
  localparam int ROWS    = 12;
  localparam int COLS    = 12;
  localparam int ROW_W   = COLS * PIX_W;
  localparam int FRAME_W = ROWS * ROW_W;
  localparam int FILT_W  = 9 * PIX_W;
  localparam int CNT_W   = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_e;
endpackage

// File: rtl/conv12_frame_loader_if.sv
// Row input, filter write and frame output handshakes of the frame loader.
interface conv12_frame_loader_if;
  import conv12_pkg::*;

  logic               row_valid;
  logic               row_ready;
  logic               row_first;
  logic [ROW_W-1:0]   row_data;
  logic               flt_we;
  logic [FILT_W-1:0]  flt_data;
  logic               frame_valid;
  logic               frame_ready;
  logic [FRAME_W-1:0] frame_out;
  logic [FILT_W-1:0]  filter_out;
  logic               resync;

  modport master (
    output row_valid, row_first, row_data, flt_we, flt_data, frame_ready,
    input  row_ready, frame_valid, frame_out, filter_out, resync
  );

  modport slave (
    input  row_valid, row_first, row_data, flt_we, flt_data, frame_ready,
    output row_ready, frame_valid, frame_out, filter_out, resync
  );
endinterface

// File: rtl/conv12_row_store.sv
// 12-row fill register: one row written per cycle, whole frame readable flat.
module conv12_row_store
  import conv12_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [CNT_W-1:0]   wr_idx,
  input  logic [ROW_W-1:0]   wr_data,
  output logic [FRAME_W-1:0] rd_frame
);
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      logic [ROW_W-1:0] row_q;
      logic [ROW_W-1:0] row_d;

      always_comb begin
        row_d = row_q;
        if (wr_en && (wr_idx == CNT_W'(gi))) row_d = wr_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) row_q <= '0;
        else        row_q <= row_d;
      end

      assign rd_frame[ROW_W*gi +: ROW_W] = row_q;
    end
  endgenerate
endmodule

// File: rtl/conv12_frame_loader.sv
// Assembles 12 rows into a frame and hands it, with its bound filter, to the
// convolution stage through a registered valid/ready output (two-deep buffering).
module conv12_frame_loader
  import conv12_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  conv12_frame_loader_if.slave  bus
);
  fill_state_e        state_q, state_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic               frame_valid_q, frame_valid_d;
  logic [FRAME_W-1:0] frame_out_q, frame_out_d;
  logic [FILT_W-1:0]  filter_out_q, filter_out_d;
  logic [FILT_W-1:0]  shadow_q, shadow_d;
  logic               resync_q, resync_d;

  logic               row_acc;
  logic               xfer;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_idx;
  logic [FRAME_W-1:0] fill_frame;

  conv12_row_store u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (bus.row_data),
    .rd_frame (fill_frame)
  );

  always_comb begin
    state_d       = state_q;
    row_cnt_d     = row_cnt_q;
    frame_valid_d = frame_valid_q;
    frame_out_d   = frame_out_q;
    filter_out_d  = filter_out_q;
    shadow_d      = shadow_q;
    resync_d      = 1'b0;

    row_acc = bus.row_valid && (state_q == FILL);
    xfer    = (state_q == FULL) && (!frame_valid_q || bus.frame_ready);
    wr_en   = row_acc;
    wr_idx  = bus.row_first ? '0 : row_cnt_q;

    if (row_acc) begin
      if (bus.row_first) begin
        // A new frame start restarts the fill; any partial frame is dropped.
        row_cnt_d = CNT_W'(1);
        resync_d  = (row_cnt_q != '0);
      end else if (row_cnt_q == CNT_W'(ROWS - 1)) begin
        row_cnt_d = '0;
        state_d   = FULL;
      end else begin
        row_cnt_d = row_cnt_q + CNT_W'(1);
      end
    end

    if (xfer) begin
      state_d       = FILL;
      frame_out_d   = fill_frame;
      filter_out_d  = shadow_q;
      frame_valid_d = 1'b1;
    end else if (frame_valid_q && bus.frame_ready) begin
      frame_valid_d = 1'b0;
    end

    // The old shadow has already been sampled above if a transfer coincides.
    if (bus.flt_we) shadow_d = bus.flt_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      row_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_out_q   <= '0;
      filter_out_q  <= '0;
      shadow_q      <= '0;
      resync_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_out_q   <= frame_out_d;
      filter_out_q  <= filter_out_d;
      shadow_q      <= shadow_d;
      resync_q      <= resync_d;
    end
  end

  assign bus.row_ready   = (state_q == FILL);
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_out   = frame_out_q;
  assign bus.filter_out  = filter_out_q;
  assign bus.resync      = resync_q;
endmodule
